// File: rtl/ntt_mdc_reorder_pkg.sv
// Shared types and helpers for the NTT output reorder buffer.
// Holds the FSM encodings plus bit-reversal and ceil-log2 helpers.
package ntt_mdc_reorder_pkg;

    typedef enum logic {
        WR_S_IDLE = 1'b0,
        WR_S_WR   = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_S_IDLE = 1'b0,
        RD_S_RD   = 1'b1
    } rd_state_e;

    // Reverses the low 'width' bits of value; upper result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] v;
        logic [31:0] r;
        v = value;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = {r[30:0], v[0]};
                v = {1'b0, v[31:1]};
            end
        end
        return r;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bram.sv
// Simple dual-port buffer RAM with a LATENCY-deep registered read path.
// The head stage only loads on a read, so the output holds the last word read.
module reorder_bram
    import ntt_mdc_reorder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);
    localparam int PW = LATENCY * WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    pipe_r;
    logic [WIDTH-1:0] head_s;

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head of the read pipeline: new word on a read, otherwise hold.
    always_comb begin
        if (re) begin
            head_s = mem[raddr];
        end else begin
            head_s = pipe_r[WIDTH-1:0];
        end
    end

    // Read pipeline shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_r <= {PW{1'b0}};
        end else begin
            pipe_r <= (pipe_r << WIDTH) | PW'(head_s);
        end
    end

    assign rdata = pipe_r[PW-1 -: WIDTH];

endmodule

// File: rtl/ntt_mdc_reorder.sv
// Two-lane ping-pong reorder buffer: bit-reversed NTT output in, natural order out.
// Lane 0 emits index j, lane 1 emits index j+N/2; back-to-back frames stream gap-free.
module ntt_mdc_reorder
    import ntt_mdc_reorder_pkg::*;
#(
    parameter int LOGQ       = 16,
    parameter int LOGN       = 3,
    parameter int DELAY_BRAM = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            intt,
    input  logic            in_start,
    input  logic [LOGQ-1:0] in_0,
    input  logic [LOGQ-1:0] in_1,
    output logic            out_start,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_0,
    output logic [LOGQ-1:0] out_1,
    output logic            busy,
    output logic            err
);
    localparam int KW = LOGN - 1;

    if (DELAY_BRAM < 1) begin : g_bad_delay
        $error("ntt_mdc_reorder: DELAY_BRAM must be at least 1");
    end
    if (LOGN < 2) begin : g_bad_logn
        $error("ntt_mdc_reorder: LOGN must be at least 2");
    end

    wr_state_e             wr_state_r;
    wr_state_e             wr_state_s;
    rd_state_e             rd_state_r;
    rd_state_e             rd_state_s;
    logic [KW-1:0]         k_r;
    logic [KW-1:0]         j_r;
    logic [KW-1:0]         cur_k_s;
    logic                  wr_page_r;
    logic                  rd_page_r;
    logic                  intt_r;
    logic                  err_r;
    logic [DELAY_BRAM-1:0] vld_pipe_r;
    logic [DELAY_BRAM-1:0] start_pipe_r;
    logic                  beat_s;
    logic                  restart_s;
    logic                  last_beat_s;
    logic                  rd_last_s;
    logic                  cur_intt_s;
    logic                  we_s;
    logic                  re_s;
    logic                  first_rd_s;
    logic [LOGN-1:0]       waddr_s;
    logic [LOGN-1:0]       raddr_s;

    // Beat qualification: in_start carries beat 0, so it counts even from IDLE.
    always_comb begin
        beat_s      = in_start || (wr_state_r == WR_S_WR);
        restart_s   = in_start && (wr_state_r == WR_S_WR);
        cur_k_s     = in_start ? {KW{1'b0}} : k_r;
        cur_intt_s  = in_start ? intt : intt_r;
        last_beat_s = beat_s && (&cur_k_s);
        rd_last_s   = (rd_state_r == RD_S_RD) && (&j_r);
    end

    // Next-state logic for the write and read FSMs.
    always_comb begin
        wr_state_s = WR_S_IDLE;
        case (wr_state_r)
            WR_S_IDLE: begin
                if (in_start && !last_beat_s) begin
                    wr_state_s = WR_S_WR;
                end else begin
                    wr_state_s = WR_S_IDLE;
                end
            end
            WR_S_WR: begin
                if (last_beat_s) begin
                    wr_state_s = WR_S_IDLE;
                end else begin
                    wr_state_s = WR_S_WR;
                end
            end
            default: wr_state_s = WR_S_IDLE;
        endcase

        rd_state_s = RD_S_IDLE;
        case (rd_state_r)
            RD_S_IDLE: begin
                if (last_beat_s) begin
                    rd_state_s = RD_S_RD;
                end else begin
                    rd_state_s = RD_S_IDLE;
                end
            end
            RD_S_RD: begin
                // A page handed over on our last read chains straight into the next frame.
                if (last_beat_s || !rd_last_s) begin
                    rd_state_s = RD_S_RD;
                end else begin
                    rd_state_s = RD_S_IDLE;
                end
            end
            default: rd_state_s = RD_S_IDLE;
        endcase
    end

    // FSM outputs: memory port controls.
    always_comb begin
        we_s = beat_s;
        if (cur_intt_s) begin
            waddr_s = {wr_page_r, cur_k_s};
        end else begin
            waddr_s = {wr_page_r, KW'(bitrev(32'(cur_k_s), KW))};
        end
        re_s       = (rd_state_r == RD_S_RD);
        raddr_s    = {rd_page_r, j_r};
        first_rd_s = re_s && (j_r == {KW{1'b0}});
    end

    // State, counters, page pointers and output-side pipelines.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r   <= WR_S_IDLE;
            rd_state_r   <= RD_S_IDLE;
            k_r          <= {KW{1'b0}};
            j_r          <= {KW{1'b0}};
            wr_page_r    <= 1'b0;
            rd_page_r    <= 1'b0;
            intt_r       <= 1'b0;
            err_r        <= 1'b0;
            vld_pipe_r   <= {DELAY_BRAM{1'b0}};
            start_pipe_r <= {DELAY_BRAM{1'b0}};
        end else begin
            wr_state_r <= wr_state_s;
            rd_state_r <= rd_state_s;
            err_r      <= restart_s;
            if (in_start) begin
                intt_r <= intt;
            end
            if (beat_s) begin
                k_r <= cur_k_s + KW'(1'b1);
            end
            if (last_beat_s) begin
                wr_page_r <= ~wr_page_r;
                rd_page_r <= wr_page_r;
                j_r       <= {KW{1'b0}};
            end else if (re_s) begin
                j_r <= j_r + KW'(1'b1);
            end
            vld_pipe_r   <= (vld_pipe_r << 1) | DELAY_BRAM'(re_s);
            start_pipe_r <= (start_pipe_r << 1) | DELAY_BRAM'(first_rd_s);
        end
    end

    reorder_bram #(
        .WIDTH  (LOGQ),
        .DEPTH  (1 << LOGN),
        .LATENCY(DELAY_BRAM)
    ) u_bank0 (
        .clk  (clk),
        .rst  (rst),
        .we   (we_s),
        .waddr(waddr_s),
        .wdata(in_0),
        .re   (re_s),
        .raddr(raddr_s),
        .rdata(out_0)
    );

    reorder_bram #(
        .WIDTH  (LOGQ),
        .DEPTH  (1 << LOGN),
        .LATENCY(DELAY_BRAM)
    ) u_bank1 (
        .clk  (clk),
        .rst  (rst),
        .we   (we_s),
        .waddr(waddr_s),
        .wdata(in_1),
        .re   (re_s),
        .raddr(raddr_s),
        .rdata(out_1)
    );

    assign out_valid = vld_pipe_r[DELAY_BRAM-1];
    assign out_start = start_pipe_r[DELAY_BRAM-1];
    assign err       = err_r;
    assign busy      = (wr_state_r != WR_S_IDLE) || (rd_state_r != RD_S_IDLE) || (|vld_pipe_r);

endmodule

// File: doc/ntt_mdc_reorder.md
Name: ntt_mdc_reorder

Overview:
- Output reorder buffer that sits directly downstream of the MDC NTT stage chain.
- Consumes the two-lane, bit-reversed coefficient stream that the last NTT stage emits, together with its finish pulse as the frame marker.
- Re-emits each frame in natural order on two lanes: lane 0 carries index j, lane 1 carries index j+N/2.
- Ping-pong paging, so back-to-back frames stream with no gaps.

Parameters:
- LOGQ, 0 — coefficient width in bits.
- LOGN, 0 — log2 of the polynomial length N; a frame is N/2 beats.
- DELAY_BRAM, 0 — read latency of the buffer memory in cycles (≥1); 0 is illegal and must be rejected at elaboration.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- intt  in  1  mode; sampled on in_start, held for that frame.
- in_start  in  1  pulse marking beat 0 of an input frame; connects to the NTT chain finish.
- in_0  in  LOGQ  input lane 0.
- in_1  in  LOGQ  input lane 1.
- out_start  out  1  pulse coincident with output beat 0.
- out_valid  out  1  high for the N/2 output beats of a frame.
- out_0  out  LOGQ  output lane 0 (index j).
- out_1  out  LOGQ  output lane 1 (index j+N/2).
- busy  out  1  high while any frame is being written or read.
- err  out  1  one-cycle pulse on a restarted (truncated) input frame.

Behaviour:
- Reset values: all outputs 0; write and read FSMs go to IDLE; page pointer 0; memory contents are not cleared.
- Input contract:
  - Beat k (k=0..N/2-1) occupies cycle in_start+k, with no gaps.
  - in_0 carries index br(2k) and in_1 carries br(2k)+N/2, where br is the LOGN-bit bit reversal.
- Storage: two banks (bank0 for lane 0, bank1 for lane 1), each 2 pages × N/2 words.
- Write address:
  - When the frame's intt=0: brev_{LOGN-1}(k).
  - When the frame's intt=1: k (identity; the INTT output is already natural).
  - Both banks are written at the same address on the same cycle.
- Write FSM:
  - IDLE→WR on in_start.
  - WR counts k to N/2-1. On the last beat it toggles the write page, hands the completed page to the read side, and returns to IDLE.
  - If in_start coincides with the last beat's following cycle, WR→WR directly (back-to-back frames).
- Read FSM:
  - IDLE→RD on the cycle after the last write beat (cycle t+1, where t is the last beat).
  - Issues read addresses j=0..N/2-1 on cycles t+1..t+N/2 from the completed page.
  - Data appears DELAY_BRAM cycles later.
  - out_start = 1 and out_valid = 1 at cycle t+1+DELAY_BRAM; out_valid stays high for N/2 cycles.
  - Outputs are registered. out_0/out_1 hold their last value when out_valid=0.
- Latency: in_start to out_start is exactly N/2+DELAY_BRAM cycles.
- Back-to-back: the read of page P and the write of page !P overlap. Write of the following frame into P starts no earlier than t+N/2+1, after the last read of P is issued, so no overflow condition exists.
- Restart: in_start asserted while WR with k≠0 means:
  - err pulses for one cycle.
  - k resets to 0 on the same page (the partial frame is discarded; no read is launched for it).
  - intt is re-sampled.
- Simultaneous events: a read in progress is never disturbed by a restart on the other page.
- busy = (write FSM ≠ IDLE) or (read FSM ≠ IDLE) or the read pipeline is non-empty.
- rst mid-frame: aborts both FSMs next edge; out_valid/out_start drop to 0; in-flight reads are discarded.

Decomposition:
- Shared package: bitrev function (width parameter); clog2; FSM state encodings (IDLE, WR / IDLE, RD).
- One sub-module: reorder_bram, a simple dual-port RAM with depth N words (the page bit is the address MSB), width LOGQ, and read latency DELAY_BRAM. Instantiate it twice, once per bank.

Test Plan:
- Single frame: LOGN=3, DELAY_BRAM=2, intt=0, value = 100+index.
  - Stimulus: in_0 = 100,102,101,103 and in_1 = 104,106,105,107 over 4 beats.
  - Required: out_start 6 cycles after in_start; out pairs (100,104), (101,105), (102,106), (103,107).
- intt=1: same LOGN and latency.
  - Stimulus: in_0 = 200..203, in_1 = 210..213.
  - Required: out_0 = 200..203 and out_1 = 210..213, unchanged order.
- Back-to-back: three frames with in_start at cycles 0, 4, 8.
  - Required: out_valid high continuously for 12 cycles from cycle 6; each frame correctly reordered; err never asserted.
- Restart: in_start at cycle 0, then again at cycle 2, then 4 clean beats.
  - Required: err pulses at cycle 2; exactly one output frame (the second) at cycle 8.
- Reset mid-read: rst asserted at the 2nd output beat.
  - Required: out_valid=0, busy=0, and out_0=out_1=0 the following cycle; a subsequent frame outputs correctly.
- Random regression: LOGN=5, DELAY_BRAM=1, 50 random frames with random idle gaps.
  - Required: matches a golden bit-reversal model; latency is always 17 cycles.
